uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
Parametrised successor to the single-byte UART transmitter. It accepts words over a valid/ready handshake into an internal FIFO and serialises them LSB-first. Data width, parity mode, stop-bit count and baud are configurable, and a CTS_n input provides hardware flow control. It sits between the command/packet logic on clk_Tx and the board TX pin, and emits back-to-back frames with no idle gap while data is queued.

Parameters:
CLK_HZ, 100000000, clk_Tx frequency in Hz
BAUD, 9600, line rate; DIV = (CLK_HZ + BAUD/2) / BAUD clocks per bit (10417 at defaults); DIV >= 4 required
DATA_BITS, 8, data bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, legal 1 or 2
FIFO_DEPTH, 4, word slots, power of two, >= 2

Ports:
clk_Tx  in  1  system clock
reset  in  1  asynchronous, active-low reset
tx_data  in  DATA_BITS  word to send
tx_valid  in  1  tx_data valid
tx_ready  out  1  FIFO can accept a word (count < FIFO_DEPTH)
cts_n  in  1  low = remote may receive; sampled only in IDLE
tx_out  out  1  serial line, idle high, registered
tx_busy  out  1  high while a frame is on the line (state != IDLE)
fifo_count  out  clog2(FIFO_DEPTH)+1  words queued, excluding the frame in flight

Behaviour:
- Reset (async, reset=0): tx_out=1, tx_busy=0, tx_ready=0 while held, fifo_count=0, FIFO pointers cleared, state=IDLE, bit counter and baud counter 0. A frame in progress is abandoned immediately; tx_out goes high with no glitch low.
- tx_ready is a registered/combinational function of count only: tx_ready = (count < FIFO_DEPTH) after reset release. A push happens on an edge where tx_valid && tx_ready. tx_valid while !tx_ready is ignored; the word is not stored.
- FIFO push and pop on the same edge leave count unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: if count > 0 && cts_n == 0, pop the head into the shift register, set tx_out <= 0 and go to START, all on the same edge. Otherwise tx_out stays 1.
- START: hold for DIV clocks, then go to DATA with tx_out <= shift[0].
- DATA: each bit is held exactly DIV clocks and the shifter shifts right. After DATA_BITS bits, go to PARITY if PARITY != 0, else to STOP.
- PARITY: odd drives ~^data, even drives ^data, computed over the popped word. Hold DIV clocks.
- STOP: tx_out=1 for STOP_BITS*DIV clocks.
- At STOP end: if count > 0 && cts_n == 0, pop and enter START directly (tx_out <= 0 on that edge, no idle cycle). Otherwise go to IDLE.
- cts_n going high mid-frame does not stop the frame; it only blocks the next start.
- Latency: word pushed into an empty FIFO at edge E while IDLE with cts_n=0 → pop and tx_out low at edge E+1. The full frame lasts (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * DIV clocks.
- The baud counter runs only outside IDLE and reloads to 0 at every bit boundary. There is no cumulative drift: bit k starts exactly k*DIV clocks after the start edge.
- tx_busy = 1 from the start edge through the last STOP clock. It is 0 in IDLE.
- Unused upper tx_data bits do not exist; the width is exactly DATA_BITS.

Test Plan:
1. CLK_HZ=1000000, BAUD=100000 (DIV=10), 8N1. Push 0x72 → tx_out low 1 clk after handshake. Line reads 0,0,1,0,0,1,1,1,0,1, each held 10 clks. tx_busy high for 100 clks, then IDLE.
2. Same config with PARITY=2, STOP_BITS=2. Push 0xA5 → parity bit 0 after bit 7. Stop high for 20 clks; frame is 120 clks.
3. FIFO_DEPTH=4. Hold tx_valid with words 0x01..0x06 → first pops at once, 4 more queue, tx_ready=0 with fifo_count=4, 6th word accepted only after the next pop. Frames are back-to-back with the next start immediately after the stop-bit end and no idle clock.
4. cts_n=1, push 0x55 → tx_out stays 1 and fifo_count=1. Drop cts_n → start 1 clk later. Raise cts_n mid-frame → frame completes, queued next word waits.
5. Assert reset mid-DATA → tx_out=1 asynchronously and fifo_count=0. After release, push 0x0F → clean full frame.
6. DATA_BITS=5, PARITY=1. Push 5'b10110 → bits 0,1,1,0,1, then parity 0 (odd count of ones). Frame is 8*DIV clks.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Purpose: word handshake between packet logic and the UART transmitter FIFO.
// Latency: none, wires only.
// Backpressure: tx_ready low means the word on tx_data is not taken this edge.
//
// Signals:
//   tx_data   word to send, exactly DATA_BITS wide
//   tx_valid  tx_data valid
//   tx_ready  transmitter FIFO can accept a word
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Purpose: FIFO-buffered UART transmitter, LSB first, optional parity, 1/2 stop bits, CTS_n gating.
// Latency: word pushed into an empty FIFO while idle with cts_n low starts its frame one clock later.
// Backpressure: tx_ready drops when FIFO_DEPTH words are queued; frames run back-to-back while data waits.
//
// Ports:
//   clk_Tx        system clock
//   reset         asynchronous active-low reset
//   s_tx          slave side of the word handshake (tx_data / tx_valid / tx_ready)
//   i_cts_n       low = remote may receive; only checked when a new frame could start
//   o_tx_out      registered serial line, idle high
//   o_tx_busy     high while a frame is on the line
//   o_fifo_count  words queued, not counting the frame in flight
module uart_tx_fifo #(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk_Tx,
    input  logic                        reset,
    uart_tx_fifo_if.slave               s_tx,
    input  logic                        i_cts_n,
    output logic                        o_tx_out,
    output logic                        o_tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_count
);
    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(DIV);     // baud counter only reaches DIV-1
    localparam int BW  = 4;               // covers up to 9 data bits and 2 stop bits
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wptr;
    logic [AW-1:0]        r_rptr;
    logic [AW:0]          r_count;
    logic                 r_live;
    state_t               r_state;
    logic [CW-1:0]        r_baud_cnt;
    logic [BW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parity;
    logic                 r_tx_out;

    state_t               w_state_nxt;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_can_start;
    logic                 w_bit_end;
    logic                 w_data_last;
    logic                 w_stop_last;
    logic                 w_tx_nxt;

    // r_live keeps tx_ready low while reset is held, even though the count reads zero.
    assign s_tx.tx_ready = r_live && (r_count < DEPTH_C);
    assign w_push        = s_tx.tx_valid && s_tx.tx_ready;
    assign w_can_start   = (r_count != '0) && !i_cts_n;
    assign w_bit_end     = (r_baud_cnt == CW'(DIV - 1));
    assign w_data_last   = (r_bit_cnt == BW'(DATA_BITS - 1));
    assign w_stop_last   = (r_bit_cnt == BW'(STOP_BITS - 1));

    // State register and frame datapath.
    always_ff @(posedge clk_Tx or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_tx_out   <= 1'b1;
            r_live     <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else begin
            r_live   <= 1'b1;
            r_state  <= w_state_nxt;
            r_tx_out <= w_tx_nxt;

            // Reload at every bit boundary so bit k always starts k*DIV clocks after the start edge.
            if (r_state == S_IDLE || w_bit_end)
                r_baud_cnt <= '0;
            else
                r_baud_cnt <= r_baud_cnt + 1'b1;

            // Bit counter indexes data bits in DATA and stop bits in STOP.
            if (w_state_nxt != r_state)
                r_bit_cnt <= '0;
            else if (w_bit_end)
                r_bit_cnt <= r_bit_cnt + 1'b1;

            // Line always shows r_shift[0] at the next boundary, so shift after presenting it.
            if (w_pop) begin
                r_shift  <= r_mem[r_rptr];
                r_parity <= (PARITY == 1) ? ~^r_mem[r_rptr] : ^r_mem[r_rptr];
            end else if (w_bit_end && (r_state == S_START || r_state == S_DATA)) begin
                r_shift  <= r_shift >> 1;
            end

            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage needs no reset; pointers and count define what is valid.
    always_ff @(posedge clk_Tx) begin
        if (w_push)
            r_mem[r_wptr] <= s_tx.tx_data;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_can_start) w_state_nxt = S_START;
            S_START:  if (w_bit_end) w_state_nxt = S_DATA;
            S_DATA:   if (w_bit_end && w_data_last)
                          w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (w_bit_end) w_state_nxt = S_STOP;
            S_STOP:   if (w_bit_end && w_stop_last)
                          w_state_nxt = w_can_start ? S_START : S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: next line value and FIFO pop.
    always_comb begin
        w_pop    = 1'b0;
        w_tx_nxt = r_tx_out;
        case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (w_can_start) begin
                    w_pop    = 1'b1;
                    w_tx_nxt = 1'b0;
                end
            end
            S_START: if (w_bit_end) w_tx_nxt = r_shift[0];
            S_DATA: if (w_bit_end) begin
                if (!w_data_last)
                    w_tx_nxt = r_shift[0];
                else if (PARITY != 0)
                    w_tx_nxt = r_parity;
                else
                    w_tx_nxt = 1'b1;
            end
            S_PARITY: if (w_bit_end) w_tx_nxt = 1'b1;
            // Back-to-back frames: the next start bit begins on the edge that ends the last stop bit.
            S_STOP: if (w_bit_end && w_stop_last && w_can_start) begin
                w_pop    = 1'b1;
                w_tx_nxt = 1'b0;
            end
            default: w_tx_nxt = 1'b1;
        endcase
    end

    assign o_tx_out     = r_tx_out;
    assign o_tx_busy    = (r_state != S_IDLE);
    assign o_fifo_count = r_count;
endmodule
